// File: rtl/npc_pkg.sv
// Shared types and constants for the next-PC unit: branch funct3 codes,
// redirect-source encoding and FSM state encoding.
package npc_pkg;

   localparam int unsigned NPC_F3_W = 3;

   localparam logic [NPC_F3_W-1:0] BR_EQ  = 3'b000;
   localparam logic [NPC_F3_W-1:0] BR_NE  = 3'b001;
   localparam logic [NPC_F3_W-1:0] BR_LT  = 3'b100;
   localparam logic [NPC_F3_W-1:0] BR_GE  = 3'b101;
   localparam logic [NPC_F3_W-1:0] BR_LTU = 3'b110;
   localparam logic [NPC_F3_W-1:0] BR_GEU = 3'b111;

   typedef enum logic [2:0] {
      SRC_SEQ,
      SRC_BR,
      SRC_JMP,
      SRC_MRET,
      SRC_TRAP
   } npc_src_e;

   typedef enum logic {
      ST_RUN,
      ST_HOLD
   } npc_state_e;

   // Instruction targets must be 4-byte aligned (no compressed support)
   function automatic logic npc_misaligned(input logic [1:0] lsb);
      return lsb != 2'b00;
   endfunction

endpackage

// File: rtl/br_cond.sv
// Combinational RISC-V branch comparator; shared with a future predictor.
module br_cond
   import npc_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic [NPC_F3_W-1:0] i_funct3,
   input  logic [XLEN-1:0]     i_rs1,
   input  logic [XLEN-1:0]     i_rs2,
   output logic                o_cond_c
);

   always_comb begin
      o_cond_c = 1'b0;
      case (i_funct3)
         BR_EQ:   o_cond_c = (i_rs1 == i_rs2);
         BR_NE:   o_cond_c = (i_rs1 != i_rs2);
         BR_LT:   o_cond_c = ($signed(i_rs1) <  $signed(i_rs2));
         BR_GE:   o_cond_c = ($signed(i_rs1) >= $signed(i_rs2));
         BR_LTU:  o_cond_c = (i_rs1 <  i_rs2);
         BR_GEU:  o_cond_c = (i_rs1 >= i_rs2);
         default: o_cond_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/next_pc_unit.sv
// Architectural PC register and next-PC arbitration (trap > mret > jump > branch > seq).
// Optional target alignment check enabled by NPC_MISALIGN_CHK_EN.
module next_pc_unit
   import npc_pkg::*;
#(
   parameter int unsigned    XLEN         = 64,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int unsigned    ILEN_BYTES   = 4
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                stall_i,
   input  logic                branch_i,
   input  logic [NPC_F3_W-1:0] br_funct3_i,
   input  logic [XLEN-1:0]     rs1_i,
   input  logic [XLEN-1:0]     rs2_i,
   input  logic [XLEN-1:0]     br_target_i,
   input  logic                jump_i,
   input  logic                jalr_i,
   input  logic [XLEN-1:0]     jump_target_i,
   input  logic                trap_i,
   input  logic [XLEN-1:0]     trap_vec_i,
   input  logic                mret_i,
   input  logic [XLEN-1:0]     mepc_i,
   output logic [XLEN-1:0]     pc_o,
   output logic [XLEN-1:0]     seq_pc_o,
   output logic                redirect_o,
   output logic                taken_o,
   output logic                misalign_o
);

   npc_state_e      r_state;
   npc_state_e      w_state_nxt;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_pc_nxt;
   logic [XLEN-1:0] r_pend_pc;
   logic [XLEN-1:0] w_pend_nxt;
   logic [XLEN-1:0] w_seq_pc;
   logic [XLEN-1:0] w_tgt;
   npc_src_e        w_src;
   logic            w_cond;
   logic            w_drop;
   logic            w_redir;

   br_cond #(.XLEN(XLEN)) u_br_cond (
      .i_funct3 (br_funct3_i),
      .i_rs1    (rs1_i),
      .i_rs2    (rs2_i),
      .o_cond_c (w_cond)
   );

   assign w_seq_pc = r_pc + XLEN'(ILEN_BYTES);
   assign taken_o  = branch_i & w_cond;

   // Redirect source priority
   always_comb begin
      w_src = SRC_SEQ;
      w_tgt = w_seq_pc;
      if (trap_i) begin
         w_src = SRC_TRAP;
         w_tgt = trap_vec_i;
      end else if (mret_i) begin
         w_src = SRC_MRET;
         w_tgt = mepc_i;
      end else if (jump_i) begin
         w_src = SRC_JMP;
         w_tgt = jalr_i ? {jump_target_i[XLEN-1:1], 1'b0} : jump_target_i;
      end else if (taken_o) begin
         w_src = SRC_BR;
         w_tgt = br_target_i;
      end
   end

`ifdef NPC_MISALIGN_CHK_EN
   // Trap vectors are trusted; everything else must be word aligned
   assign w_drop = (w_src != SRC_SEQ) && (w_src != SRC_TRAP) && npc_misaligned(w_tgt[1:0]);
`else
   assign w_drop = 1'b0;
`endif

   assign w_redir    = (w_src != SRC_SEQ) && !w_drop;
   assign redirect_o = w_redir;

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_pend_nxt  = r_pend_pc;
      case (r_state)
         ST_RUN: begin
            if (!stall_i) begin
               if (w_redir) begin
                  w_pc_nxt = w_tgt;
               end else if (!w_drop) begin
                  w_pc_nxt = w_seq_pc;
               end
            end else if (w_redir) begin
               w_state_nxt = ST_HOLD;
               w_pend_nxt  = w_tgt;
            end
         end
         ST_HOLD: begin
            // Only a trap may displace the parked redirect
            if (stall_i) begin
               if (trap_i) begin
                  w_pend_nxt = trap_vec_i;
               end
            end else begin
               w_pc_nxt    = trap_i ? trap_vec_i : r_pend_pc;
               w_state_nxt = ST_RUN;
            end
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state   <= ST_RUN;
         r_pc      <= RESET_VECTOR;
         r_pend_pc <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_pc      <= w_pc_nxt;
         r_pend_pc <= w_pend_nxt;
      end
   end

`ifdef NPC_MISALIGN_CHK_EN
   logic r_misalign;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= w_drop && (r_state == ST_RUN);
      end
   end

   assign misalign_o = r_misalign;
`else
   assign misalign_o = 1'b0;
`endif

   assign pc_o     = r_pc;
   assign seq_pc_o = w_seq_pc;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed self-checking bench for next_pc_unit; table-driven vectors plus stall/reset sequences.
module tb_next_pc_unit;

   localparam int unsigned XLEN = 64;
   localparam logic [63:0] RV   = 64'h8000_0000;
   localparam logic [63:0] M1   = 64'hFFFF_FFFF_FFFF_FFFF;

   logic            clk;
   logic            rstn;
   logic            stall_i;
   logic            branch_i;
   logic [2:0]      br_funct3_i;
   logic [XLEN-1:0] rs1_i;
   logic [XLEN-1:0] rs2_i;
   logic [XLEN-1:0] br_target_i;
   logic            jump_i;
   logic            jalr_i;
   logic [XLEN-1:0] jump_target_i;
   logic            trap_i;
   logic [XLEN-1:0] trap_vec_i;
   logic            mret_i;
   logic [XLEN-1:0] mepc_i;
   logic [XLEN-1:0] pc_o;
   logic [XLEN-1:0] seq_pc_o;
   logic            redirect_o;
   logic            taken_o;
   logic            misalign_o;

   int checks = 0;
   int errors = 0;

   next_pc_unit #(.XLEN(XLEN), .RESET_VECTOR(RV), .ILEN_BYTES(4)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .stall_i       (stall_i),
      .branch_i      (branch_i),
      .br_funct3_i   (br_funct3_i),
      .rs1_i         (rs1_i),
      .rs2_i         (rs2_i),
      .br_target_i   (br_target_i),
      .jump_i        (jump_i),
      .jalr_i        (jalr_i),
      .jump_target_i (jump_target_i),
      .trap_i        (trap_i),
      .trap_vec_i    (trap_vec_i),
      .mret_i        (mret_i),
      .mepc_i        (mepc_i),
      .pc_o          (pc_o),
      .seq_pc_o      (seq_pc_o),
      .redirect_o    (redirect_o),
      .taken_o       (taken_o),
      .misalign_o    (misalign_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        br;
      logic [2:0]  f3;
      logic [63:0] rs1;
      logic [63:0] rs2;
      logic [63:0] bt;
      logic        jmp;
      logic        jalr;
      logic [63:0] jt;
      logic        trp;
      logic [63:0] tv;
      logic        mret;
      logic [63:0] mepc;
      logic        e_red;
      logic        e_tak;
      logic [63:0] e_pc;
      logic        e_mis;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input string name, input logic br, input logic [2:0] f3,
                               input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] bt,
                               input logic jmp, input logic jalr, input logic [63:0] jt,
                               input logic trp, input logic [63:0] tv,
                               input logic mret, input logic [63:0] mepc,
                               input logic e_red, input logic e_tak, input logic [63:0] e_pc,
                               input logic e_mis);
      vec_t v;
      v.name = name; v.br = br; v.f3 = f3; v.rs1 = rs1; v.rs2 = rs2; v.bt = bt;
      v.jmp = jmp; v.jalr = jalr; v.jt = jt; v.trp = trp; v.tv = tv;
      v.mret = mret; v.mepc = mepc;
      v.e_red = e_red; v.e_tak = e_tak; v.e_pc = e_pc; v.e_mis = e_mis;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      branch_i = 1'b0; br_funct3_i = 3'b000; rs1_i = '0; rs2_i = '0; br_target_i = '0;
      jump_i = 1'b0; jalr_i = 1'b0; jump_target_i = '0;
      trap_i = 1'b0; trap_vec_i = '0; mret_i = 1'b0; mepc_i = '0;
   endtask

   task automatic apply(input vec_t v);
      branch_i = v.br; br_funct3_i = v.f3; rs1_i = v.rs1; rs2_i = v.rs2; br_target_i = v.bt;
      jump_i = v.jmp; jalr_i = v.jalr; jump_target_i = v.jt;
      trap_i = v.trp; trap_vec_i = v.tv; mret_i = v.mret; mepc_i = v.mepc;
   endtask

   // One cycle with optional stall, jump and trap; returns #1 after the edge
   task automatic cyc(input logic st, input logic jmp, input logic [63:0] jt,
                      input logic trp, input logic [63:0] tv);
      @(negedge clk);
      idle_inputs();
      stall_i = st; jump_i = jmp; jump_target_i = jt; trap_i = trp; trap_vec_i = tv;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstn = 1'b0;
      stall_i = 1'b0;
      idle_inputs();

      vq.push_back(mk("idle_first", 0,3'b000,0,0,0,      0,0,0, 0,0, 0,0, 0,0,64'h8000_0004,0));
      vq.push_back(mk("blt_taken",  1,3'b100,M1,1,'h100, 0,0,0, 0,0, 0,0, 1,1,64'h100,0));
      vq.push_back(mk("bltu_nt",    1,3'b110,M1,1,'h100, 0,0,0, 0,0, 0,0, 0,0,64'h104,0));
      vq.push_back(mk("beq_t",      1,3'b000,5,5,'h200,  0,0,0, 0,0, 0,0, 1,1,64'h200,0));
      vq.push_back(mk("bne_nt",     1,3'b001,5,5,'h300,  0,0,0, 0,0, 0,0, 0,0,64'h204,0));
      vq.push_back(mk("bge_nt",     1,3'b101,M1,1,'h400, 0,0,0, 0,0, 0,0, 0,0,64'h208,0));
      vq.push_back(mk("bgeu_t",     1,3'b111,M1,1,'h400, 0,0,0, 0,0, 0,0, 1,1,64'h400,0));
      vq.push_back(mk("f3_010",     1,3'b010,5,5,'h500,  0,0,0, 0,0, 0,0, 0,0,64'h404,0));
      vq.push_back(mk("f3_011",     1,3'b011,5,5,'h500,  0,0,0, 0,0, 0,0, 0,0,64'h408,0));
      vq.push_back(mk("trap_mret_jmp", 0,3'b000,0,0,0,   1,0,'h300, 1,'h200, 1,'h600, 1,0,64'h200,0));
      vq.push_back(mk("mret_jmp_br",   1,3'b000,1,1,'h700, 1,0,'h300, 0,0, 1,'h600, 1,1,64'h600,0));
      vq.push_back(mk("jmp_br",        1,3'b000,1,1,'h700, 1,0,'h300, 0,0, 0,0, 1,1,64'h300,0));
      vq.push_back(mk("jalr_clr",   0,3'b000,0,0,0,      1,1,'h1001, 0,0, 0,0, 1,0,64'h1000,0));
      vq.push_back(mk("jmp_top",    0,3'b000,0,0,0,      1,0,64'hFFFF_FFFF_FFFF_FFFC, 0,0, 0,0,
                      1,0,64'hFFFF_FFFF_FFFF_FFFC,0));
      vq.push_back(mk("seq_wrap",   0,3'b000,0,0,0,      0,0,0, 0,0, 0,0, 0,0,64'h0,0));
`ifdef NPC_MISALIGN_CHK_EN
      vq.push_back(mk("jmp_misal",  0,3'b000,0,0,0,      1,0,'h102, 0,0, 0,0, 0,0,64'h0,1));
      vq.push_back(mk("after_misal",0,3'b000,0,0,0,      0,0,0, 0,0, 0,0, 0,0,64'h4,0));
`else
      vq.push_back(mk("jmp_misal",  0,3'b000,0,0,0,      1,0,'h102, 0,0, 0,0, 1,0,64'h102,0));
      vq.push_back(mk("after_misal",0,3'b000,0,0,0,      0,0,0, 0,0, 0,0, 0,0,64'h106,0));
`endif
      vq.push_back(mk("trap_unchk", 0,3'b000,0,0,0,      0,0,0, 1,'h202, 0,0, 1,0,64'h202,0));

      // Reset held for two edges
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc",       pc_o,       RV);
      chk("rst_seq_pc",   seq_pc_o,   RV + 64'd4);
      chk("rst_redirect", 64'(redirect_o), 64'd0);
      chk("rst_taken",    64'(taken_o),    64'd0);
      chk("rst_misalign", 64'(misalign_o), 64'd0);

      foreach (vq[i]) begin
         @(negedge clk);
         rstn = 1'b1;
         stall_i = 1'b0;
         apply(vq[i]);
         #1;
         chk({vq[i].name, "_redirect"}, 64'(redirect_o), 64'(vq[i].e_red));
         chk({vq[i].name, "_taken"},    64'(taken_o),    64'(vq[i].e_tak));
         @(posedge clk);
         #1;
         chk({vq[i].name, "_pc"},       pc_o,              vq[i].e_pc);
         chk({vq[i].name, "_seq_pc"},   seq_pc_o,          vq[i].e_pc + 64'd4);
         chk({vq[i].name, "_misalign"}, 64'(misalign_o),   64'(vq[i].e_mis));
      end

      // Known starting point for the stall sequences
      cyc(0, 0, 0, 1, 64'h1000);          chk("set_pc", pc_o, 64'h1000);

      // Jump parked during a 3-cycle stall, later jump ignored
      cyc(1, 1, 64'h40, 0, 0);            chk("stl_a1", pc_o, 64'h1000);
      cyc(1, 0, 0, 0, 0);                 chk("stl_a2", pc_o, 64'h1000);
      cyc(1, 1, 64'h50, 0, 0);            chk("stl_a3", pc_o, 64'h1000);
      cyc(0, 0, 0, 0, 0);                 chk("stl_a_rel", pc_o, 64'h40);
      cyc(0, 0, 0, 0, 0);                 chk("stl_a_seq", pc_o, 64'h44);

      // Trap during the stall overwrites the parked jump
      cyc(1, 1, 64'h40, 0, 0);            chk("stl_b1", pc_o, 64'h44);
      cyc(1, 0, 0, 1, 64'h80);            chk("stl_b2", pc_o, 64'h44);
      cyc(1, 0, 0, 0, 0);                 chk("stl_b3", pc_o, 64'h44);
      cyc(0, 0, 0, 0, 0);                 chk("stl_b_rel", pc_o, 64'h80);
      cyc(0, 0, 0, 0, 0);                 chk("stl_b_seq", pc_o, 64'h84);

      // Release cycle: trap beats parked target, jump does not
      cyc(1, 1, 64'h40, 0, 0);            chk("rel_c1", pc_o, 64'h84);
      cyc(0, 0, 0, 1, 64'hC0);            chk("rel_trap", pc_o, 64'hC0);
      cyc(1, 1, 64'h40, 0, 0);            chk("rel_c2", pc_o, 64'hC0);
      cyc(0, 1, 64'h60, 0, 0);            chk("rel_jmp_ign", pc_o, 64'h40);
      cyc(0, 0, 0, 0, 0);                 chk("rel_seq", pc_o, 64'h44);

      // Reset mid-stall discards the parked redirect
      cyc(1, 1, 64'h40, 0, 0);            chk("rst_stl1", pc_o, 64'h44);
      @(negedge clk);
      idle_inputs();
      rstn = 1'b0;
      stall_i = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_stl_pc", pc_o, RV);
      @(negedge clk);
      rstn = 1'b1;
      stall_i = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_stl_free", pc_o, RV + 64'd4);
      cyc(0, 0, 0, 0, 0);                 chk("rst_stl_seq", pc_o, RV + 64'd8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
